// File: rtl/sysref_burst_gate_pkg.sv
// sysref_burst_gate shared types and default widths.
// Imported by the gate top and its period monitor.
package sysref_burst_gate_pkg;

    localparam int BURST_W_DEF  = 8;
    localparam int PERIOD_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_BURST = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/sysref_burst_gate_period_monitor.sv
// SYSREF period measurement and sticky deviation flag.
// cnt holds cycles since the last rising edge.
module sysref_period_monitor
    import sysref_burst_gate_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rise_i,
    input  logic [PERIOD_W-1:0] expected_period_i,
    input  logic [3:0]          period_tol_i,
    input  logic                error_clr_i,
    output logic [PERIOD_W-1:0] period_meas_o,
    output logic                period_valid_o,
    output logic                period_error_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] meas_q, meas_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic                seen_q, seen_d;

    logic signed [PERIOD_W:0] diff;
    logic        [PERIOD_W:0] absd;
    logic                     viol;

    // Next-state for counter, measurement and error flag.
    always_comb begin
        diff = $signed({1'b0, cnt_q}) - $signed({1'b0, expected_period_i});
        absd = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
        viol = rise_i && seen_q && (expected_period_i != '0)
               && (absd > {{(PERIOD_W-3){1'b0}}, period_tol_i});
        if (rise_i) begin
            cnt_d = PERIOD_W'(1);
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        valid_d = rise_i && seen_q;
        meas_d  = valid_d ? cnt_q : meas_q;
        seen_d  = seen_q | rise_i;
        // A new violation wins over a simultaneous clear.
        if (viol) begin
            error_d = 1'b1;
        end else if (error_clr_i) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
    end

    // Monitor registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            meas_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            valid_q <= valid_d;
            error_q <= error_d;
            seen_q  <= seen_d;
        end
    end

    assign period_meas_o  = meas_q;
    assign period_valid_o = valid_q;
    assign period_error_o = error_q;

endmodule

// File: rtl/sysref_burst_gate.sv
// SYSREF burst gate: passes whole SYSREF pulses on arm,
// bounded by a pulse count or open until abort.
module sysref_burst_gate
    import sysref_burst_gate_pkg::*;
#(
    parameter int BURST_W  = BURST_W_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sysref_in,
    input  logic                arm,
    input  logic                abort,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic                continuous,
    input  logic [PERIOD_W-1:0] expected_period,
    input  logic [3:0]          period_tol,
    input  logic                error_clr,
    output logic                sysref_out,
    output logic                busy,
    output logic                done,
    output logic [PERIOD_W-1:0] period_meas,
    output logic                period_valid,
    output logic                period_error,
    output logic [2:0]          state
);

    state_e             state_q, state_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;
    logic [BURST_W-1:0] pcnt_nxt;
    logic               cont_q, cont_d;
    logic               sysref_dly_q;
    logic               out_q;
    logic               rise, fall, open;

    assign rise     = sysref_in & ~sysref_dly_q;
    assign fall     = ~sysref_in & sysref_dly_q;
    assign pcnt_nxt = pcnt_q + 1'b1;

    // An abort coinciding with the first rise wins, so no
    // one-cycle runt leaks out on that edge.
    assign open = (state_q == ST_BURST) || (state_q == ST_DRAIN)
               || ((state_q == ST_ARMED) && rise && !abort);

    // Burst FSM next-state and latched burst parameters.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cont_d  = cont_q;
        pcnt_d  = pcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    len_d   = (burst_len == '0) ? BURST_W'(1)
                                                : burst_len;
                    cont_d  = continuous;
                    pcnt_d  = '0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rise) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (fall) begin
                    pcnt_d = pcnt_nxt;
                end
                if (fall && !cont_q && (pcnt_nxt == len_q)) begin
                    state_d = ST_DONE;
                end else if (abort) begin
                    state_d = sysref_in ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (fall) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, parameter latches, edge delay and gated output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            cont_q       <= 1'b0;
            pcnt_q       <= '0;
            sysref_dly_q <= 1'b0;
            out_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cont_q       <= cont_d;
            pcnt_q       <= pcnt_d;
            sysref_dly_q <= sysref_in;
            out_q        <= sysref_in & open;
        end
    end

    assign sysref_out = out_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign state      = state_q;

    sysref_period_monitor #(
        .PERIOD_W (PERIOD_W)
    ) u_mon (
        .clk               (clk),
        .rstn              (rstn),
        .rise_i            (rise),
        .expected_period_i (expected_period),
        .period_tol_i      (period_tol),
        .error_clr_i       (error_clr),
        .period_meas_o     (period_meas),
        .period_valid_o    (period_valid),
        .period_error_o    (period_error)
    );

endmodule

// File: tb/tb_sysref_burst_gate.sv
// Directed bench for sysref_burst_gate.
// Periodic SYSREF source, pulse monitor, checker task.
module tb_sysref_burst_gate;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sysref_in = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  burst_len = '0;
    logic        continuous = 1'b0;
    logic [15:0] expected_period = '0;
    logic [3:0]  period_tol = '0;
    logic        error_clr = 1'b0;
    logic        sysref_out;
    logic        busy;
    logic        done;
    logic [15:0] period_meas;
    logic        period_valid;
    logic        period_error;
    logic [2:0]  state;

    int  n_run = 0;
    int  n_fail = 0;
    bit  gen_en = 1'b0;
    int  per = 16;
    int  wid = 4;
    int  ph = 0;

    int  n_rise = 0, n_fall = 0, n_done = 0, n_valid = 0;
    int  lat_err = 0, wid_err = 0, fall_at_done = 0, wcnt = 0;
    bit  in_prev = 1'b0, out_prev = 1'b0;

    int  b_rise, b_fall, b_done, b_valid, b_lat, b_wid;
    bit  ok;

    sysref_burst_gate dut (
        .clk             (clk),
        .rstn            (rstn),
        .sysref_in       (sysref_in),
        .arm             (arm),
        .abort           (abort),
        .burst_len       (burst_len),
        .continuous      (continuous),
        .expected_period (expected_period),
        .period_tol      (period_tol),
        .error_clr       (error_clr),
        .sysref_out      (sysref_out),
        .busy            (busy),
        .done            (done),
        .period_meas     (period_meas),
        .period_valid    (period_valid),
        .period_error    (period_error),
        .state           (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!gen_en) begin
            sysref_in = 1'b0;
            ph = 0;
        end else begin
            sysref_in = (ph < wid);
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end
    end

    always @(negedge clk) begin
        if (sysref_out && !in_prev) lat_err++;
        if (sysref_out && !out_prev) begin
            n_rise++;
            wcnt = 1;
        end else if (sysref_out) begin
            wcnt++;
        end
        if (!sysref_out && out_prev) begin
            n_fall++;
            if (wcnt != wid) wid_err++;
        end
        if (done) begin
            n_done++;
            fall_at_done = n_fall;
        end
        if (period_valid) n_valid++;
        in_prev  = sysref_in;
        out_prev = sysref_out;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_rise  = n_rise;
        b_fall  = n_fall;
        b_done  = n_done;
        b_valid = n_valid;
        b_lat   = lat_err;
        b_wid   = wid_err;
    endtask

    task automatic wait_in_rise(output bit r);
        bit p;
        r = 1'b0;
        p = sysref_in;
        for (int n = 0; n < 100 && !r; n++) begin
            @(negedge clk);
            if (sysref_in && !p) r = 1'b1;
            p = sysref_in;
        end
    endtask

    task automatic wait_busy_low(output bit r);
        r = 1'b0;
        for (int n = 0; n < 400 && !r; n++) begin
            @(negedge clk);
            if (!busy) r = 1'b1;
        end
    endtask

    task automatic wait_rises(input int target, output bit r);
        r = 1'b0;
        for (int n = 0; n < 300 && !r; n++) begin
            @(negedge clk);
            if (n_rise >= target) r = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit r);
        r = 1'b0;
        for (int n = 0; n < 100 && !r; n++) begin
            @(negedge clk);
            if (period_valid) r = 1'b1;
        end
    endtask

    task automatic wait_out_high(output bit r);
        r = 1'b0;
        for (int n = 0; n < 100 && !r; n++) begin
            @(negedge clk);
            if (sysref_out) r = 1'b1;
        end
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out", sysref_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_meas", period_meas, 0);
        chk("rst_valid", period_valid, 0);
        chk("rst_err", period_error, 0);
        chk("rst_state", state, 0);
        tick();
        rstn = 1'b1;
        gen_en = 1'b1;
        expected_period = 16'd16;
        period_tol = 4'd2;
        repeat (40) tick();

        // bounded burst of 3
        snap();
        burst_len = 8'd3;
        continuous = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        burst_len = 8'd7;
        repeat (2) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_busy_low(ok);
        chk("t1_tmo", ok, 1);
        repeat (40) tick();
        chk("t1_pulses", n_rise - b_rise, 3);
        chk("t1_width", wid_err - b_wid, 0);
        chk("t1_lat", lat_err - b_lat, 0);
        chk("t1_done", n_done - b_done, 1);
        chk("t1_done_at", fall_at_done - b_fall, 3);
        chk("t1_busy", busy, 0);
        chk("t1_meas", period_meas, 16);
        chk("t1_err", period_error, 0);

        // continuous, abort mid 5th pulse
        wait_in_rise(ok);
        chk("t2_tmo_a", ok, 1);
        repeat (14) tick();
        snap();
        continuous = 1'b1;
        burst_len = 8'd2;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t2_armed", state, 1);
        wait_rises(b_rise + 5, ok);
        chk("t2_tmo_b", ok, 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t2_drain", state, 3);
        wait_busy_low(ok);
        chk("t2_tmo_c", ok, 1);
        repeat (40) tick();
        chk("t2_pulses", n_rise - b_rise, 5);
        chk("t2_width", wid_err - b_wid, 0);
        chk("t2_lat", lat_err - b_lat, 0);
        chk("t2_done", n_done - b_done, 1);
        continuous = 1'b0;

        // abort in ARMED
        wait_in_rise(ok);
        chk("t3_tmo", ok, 1);
        snap();
        burst_len = 8'd3;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t3_armed", state, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_idle", state, 0);
        repeat (40) tick();
        chk("t3_pulses", n_rise - b_rise, 0);
        chk("t3_done", n_done - b_done, 0);

        // burst_len 0 acts as 1
        snap();
        burst_len = 8'd0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_busy_low(ok);
        chk("t4_tmo", ok, 1);
        repeat (40) tick();
        chk("t4_pulses", n_rise - b_rise, 1);
        chk("t4_width", wid_err - b_wid, 0);
        chk("t4_done", n_done - b_done, 1);

        // period step 16 -> 20
        wait_in_rise(ok);
        chk("t5_tmo_a", ok, 1);
        per = 20;
        repeat (2) tick();
        wait_valid(ok);
        chk("t5_tmo_b", ok, 1);
        chk("t5_meas20", period_meas, 20);
        chk("t5_err_set", period_error, 1);
        per = 16;
        repeat (15) tick();
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;
        @(negedge clk);
        chk("t5_valid16", period_valid, 1);
        chk("t5_meas16", period_meas, 16);
        chk("t5_err_clr", period_error, 0);
        per = 20;
        repeat (19) tick();
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;
        @(negedge clk);
        chk("t5_valid20", period_valid, 1);
        chk("t5_meas20b", period_meas, 20);
        chk("t5_set_wins", period_error, 1);
        per = 16;
        tick();
        chk("t5_valid_pulse", period_valid, 0);
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;
        chk("t5_err_clr2", period_error, 0);
        repeat (40) tick();

        // reset mid-burst
        burst_len = 8'd3;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_out_high(ok);
        chk("t6_tmo_a", ok, 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("t6_out", sysref_out, 0);
        chk("t6_state", state, 0);
        chk("t6_meas", period_meas, 0);
        chk("t6_busy", busy, 0);
        wait_in_rise(ok);
        chk("t6_tmo_b", ok, 1);
        repeat (6) tick();
        rstn = 1'b1;
        snap();
        wait_in_rise(ok);
        chk("t6_tmo_c", ok, 1);
        repeat (3) tick();
        chk("t6_no_valid", n_valid - b_valid, 0);
        wait_in_rise(ok);
        chk("t6_tmo_d", ok, 1);
        repeat (3) tick();
        chk("t6_valid", n_valid - b_valid, 1);
        chk("t6_meas16", period_meas, 16);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sysref_burst_gate.md
Name: sysref_burst_gate

Overview:
- Sits directly downstream of the BSYNC/SYSREF generator, in the device_clk domain; consumes its free-running periodic sysref.
- On software arm, passes a bounded burst of whole SYSREF pulses (or a continuous gated stream) to the JESD link layer, never emitting runt pulses.
- Also measures the SYSREF period and flags deviation from the expected ratio.

Parameters:
BURST_W, 8, width of the pulse-count field burst_len.
PERIOD_W, 16, width of the period counter and of the expected_period / period_meas fields.

Ports:
clk  in  1  device clock; all logic is in this domain.
rstn  in  1  asynchronous active-low reset.
sysref_in  in  1  free-running SYSREF, already synchronous to clk.
arm  in  1  single-cycle request to start a burst.
abort  in  1  single-cycle request to stop the burst or disarm.
burst_len  in  BURST_W  number of pulses per burst; sampled at arm.
continuous  in  1  1 = gate stays open until abort; sampled at arm.
expected_period  in  PERIOD_W  nominal cycles between rising edges; 0 disables the check.
period_tol  in  4  allowed absolute deviation, in cycles.
error_clr  in  1  clears period_error.
sysref_out  out  1  gated SYSREF.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse at the end of a burst or a drain.
period_meas  out  PERIOD_W  last measured period.
period_valid  out  1  one-cycle pulse when period_meas updates.
period_error  out  1  sticky period-deviation flag.
state  out  3  current FSM state, for the regmap.

Behaviour:
- Reset values: every output is 0; the FSM is in IDLE; the period monitor has no previous edge recorded.
- Edge detection: sysref_d <= sysref_in.
  - rise = sysref_in & ~sysref_d
  - fall = ~sysref_in & sysref_d
- Gate: open = (state==BURST) | (state==DRAIN) | (state==ARMED & rise).
- Output: sysref_out <= sysref_in & open. Fixed latency of 1 cycle; a passed pulse has exactly the width of the input pulse.
- FSM states (encoded in the package): IDLE=0, ARMED=1, BURST=2, DRAIN=3, DONE=4.
- IDLE:
  - On arm: latch burst_len (a value of 0 is latched as 1) and continuous, clear pulse_cnt, go to ARMED.
  - abort in IDLE has no effect.
- ARMED:
  - abort has priority over rise: go to IDLE with no done pulse.
  - Otherwise rise goes to BURST. The pulse that caused the transition is passed.
- BURST:
  - On each fall, pulse_cnt increments.
  - If !continuous and pulse_cnt+1 == burst_len on that fall, go to DONE. The gate closes after the falling edge, so the last pulse is whole.
  - abort: if sysref_in is high, go to DRAIN; otherwise go to DONE.
  - If abort and the terminating fall occur in the same cycle, go to DONE.
- DRAIN: hold the gate open until fall, then go to DONE.
- DONE: done=1 for this one cycle, then go to IDLE.
- arm while busy is ignored.
- Parameter changes while busy are ignored, because they are latched at arm.
- Period monitor:
  - cnt resets to 1 on rise, otherwise increments, saturating at all-ones.
  - On rise, when a previous edge exists: period_meas <= cnt and period_valid pulses.
  - If expected_period != 0 and |cnt - expected_period| > period_tol, period_error is set.
  - Arithmetic uses PERIOD_W+1 bits, signed difference.
- period_error is cleared by error_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-burst: sysref_out drops asynchronously and the block returns to IDLE. A truncated pulse here is accepted.

Decomposition:
- Package sysref_burst_gate_pkg holds:
  - the state enum (3-bit typedef) and its values;
  - default widths BURST_W_DEF=8 and PERIOD_W_DEF=16.
- One sub-module, sysref_period_monitor: cnt, period_meas, period_valid and period_error logic, instantiated once.
- The FSM and gate stay in the top module.

Test Plan:
- Input period 16, pulse width 4; arm with burst_len=3 -> exactly 3 four-cycle pulses on sysref_out, each delayed 1 cycle from sysref_in; done pulses once after the 3rd fall; busy then drops.
- Assert arm 2 cycles before a rise with continuous=1; abort in the middle of the 5th pulse -> state goes to DRAIN; the 5th pulse is output whole; done fires; no further pulses.
- Abort in ARMED before any rise -> IDLE, no output pulse, no done.
- burst_len=0 -> behaves as 1: a single pulse, then done.
- Period steps 16 -> 20 with expected_period=16, period_tol=2 -> period_meas=20, period_valid pulses, period_error sets; error_clr on a clean edge clears it; error_clr coinciding with a new violation leaves it set.
- Assert rstn low mid-pulse in BURST -> sysref_out=0 immediately, state=0, period_meas=0; after release the first rise produces no period_valid.
